// File: rtl/pipeline_control_unit.sv
// Pipeline hazard/flow controller: load-use stalls, branch flushes, halt drain
// and debug single-step, plus a count of cycles in which the PC advanced.
module pipeline_control_unit #(
  parameter int NB           = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read_2_3,
  input  logic [NB-1:0] rt_2_3,
  input  logic [NB-1:0] rs_1_2,
  input  logic [NB-1:0] rt_1_2,
  input  logic          branch_taken,
  input  logic          halt_decoded,
  input  logic          step_mode,
  input  logic          step_req,
  output logic          pc_enable,
  output logic          if_id_write,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_ex_mem,
  output logic          halted,
  output logic [31:0]   cycle_count,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] STEP_WAIT = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;
  localparam logic [1:0] HALTED    = 2'd3;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic        step_prev_q;
  logic [31:0] cycle_q;
  logic        load_use;
  logic        step_rise;
  logic        apply_run;

  assign load_use  = mem_read_2_3 & (rt_2_3 != '0) &
                     ((rt_2_3 == rs_1_2) | (rt_2_3 == rt_1_2));
  // step_req is a level; one step is granted per rising edge while step_mode=1.
  assign step_rise = step_req & ~step_prev_q;

  always_comb begin
    pc_enable    = 1'b0;
    if_id_write  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    apply_run    = 1'b0;

    case (state_q)
      RUN: begin
        if (step_mode && !step_rise) state_d = STEP_WAIT;
        else                         apply_run = 1'b1;
      end
      STEP_WAIT: begin
        if (!step_mode)     state_d = RUN;
        else if (step_rise) apply_run = 1'b1;
      end
      DRAIN: begin
        flush_if_id = 1'b1;
        drain_d     = drain_q - 4'd1;
        if (drain_q <= 4'd1) state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase

    // Normal flow rules; branch outranks halt, halt outranks the load-use stall.
    if (apply_run) begin
      if (branch_taken) begin
        pc_enable    = 1'b1;
        if_id_write  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (halt_decoded) begin
        flush_if_id = 1'b1;
        drain_d     = DRAIN_LOAD;
      end else if (load_use) begin
        flush_id_ex = 1'b1;
      end else begin
        pc_enable   = 1'b1;
        if_id_write = 1'b1;
      end
      if (!branch_taken && halt_decoded) state_d = DRAIN;
      else if (step_mode)                state_d = STEP_WAIT;
      else                               state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      step_prev_q <= 1'b0;
      cycle_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      step_prev_q <= step_req;
      if (pc_enable) cycle_q <= cycle_q + 32'd1;
    end
  end

  assign halted      = (state_q == HALTED);
  assign cycle_count = cycle_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter NB, default 5, meaning register-index width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, meaning cycles to empty the pipeline after halt decode (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_read_2_3  input  1  instruction in ID/EX is a load.
REQ-006 SHALL have port rt_2_3  input  NB  destination of the load in ID/EX.
REQ-007 SHALL have ports rs_1_2, rt_1_2  input  NB each  source registers of the instruction in IF/ID.
REQ-008 SHALL have port branch_taken  input  1  taken branch/jump resolved this cycle.
REQ-009 SHALL have port halt_decoded  input  1  halt instruction present in decode.
REQ-010 SHALL have ports step_mode, step_req  input  1 each  debug single-step enable and step request level.
REQ-011 SHALL have ports pc_enable, if_id_write  output  1 each  PC and IF/ID register update enables.
REQ-012 SHALL have ports flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  bubble insertion per pipeline register; flush_id_ex drives the execute stage flush.
REQ-013 SHALL have port halted  output  1  pipeline fully drained and stopped.
REQ-014 SHALL have port cycle_count  output  32  number of cycles with pc_enable=1 since reset.

Function
REQ-015 SHALL implement states RUN, STEP_WAIT, DRAIN, HALTED in a registered state variable.
REQ-016 SHALL compute enables and flushes combinationally from the current state and inputs (same-cycle effect).
REQ-017 SHALL define load_use = mem_read_2_3 & (rt_2_3 != 0) & (rt_2_3 == rs_1_2 | rt_2_3 == rt_1_2).
REQ-018 SHALL, in RUN with branch_taken=1: flush_if_id=flush_id_ex=flush_ex_mem=1, pc_enable=1, if_id_write=1; remain in RUN; branch beats halt_decoded and load_use.
REQ-019 SHALL, in RUN with halt_decoded=1 and branch_taken=0: pc_enable=0, if_id_write=0, flush_if_id=1; load the drain counter with DRAIN_CYCLES; go to DRAIN.
REQ-020 SHALL, in RUN with load_use=1 and no branch/halt: pc_enable=0, if_id_write=0, flush_id_ex=1 for exactly that cycle; the stall self-clears when the load advances.
REQ-021 SHALL, in RUN with step_mode=1 and no step edge (step_req rising, detected against its registered previous value): pc_enable=if_id_write=0, no flushes; move to STEP_WAIT.
REQ-022 SHALL, in STEP_WAIT: hold all enables 0; on a step edge, advance exactly one cycle under the RUN rules, then return to STEP_WAIT; return to RUN when step_mode=0.
REQ-023 SHALL, in DRAIN: pc_enable=if_id_write=0, flush_if_id=1; decrement the counter every cycle, ignoring step_mode and branch_taken; go to HALTED the cycle after the counter reaches 1.
REQ-024 SHALL, in HALTED: halted=1, all enables 0, no flushes; leave only on reset.
REQ-025 SHALL increment cycle_count, wrapping 0xFFFFFFFF->0, on every cycle where pc_enable=1.
REQ-026 SHALL treat a rising step_req that coincides with step_mode=0 as ignored.

Reset
REQ-027 SHALL, on posedge clk with reset=0: state=RUN, drain counter=0, step_req history=0, cycle_count=0, halted=0, regardless of the current state (including mid-DRAIN).
REQ-028 SHALL drive pc_enable=1, if_id_write=1, all flushes=0 in the first cycle after reset release, provided no hazard inputs are asserted.

Verification
REQ-029 SHALL cover load-use: mem_read_2_3=1, rt_2_3=5, rs_1_2=5 -> one cycle with pc_enable=0, flush_id_ex=1; rt_2_3=0 -> no stall.
REQ-030 SHALL cover branch/halt collision: branch_taken=1 with halt_decoded=1 -> all three flushes=1, state stays RUN, halted never asserts.
REQ-031 SHALL cover halt drain: halt_decoded pulse with DRAIN_CYCLES=4 -> pc_enable=0 immediately, halted=1 exactly 5 cycles later, cycle_count frozen.
REQ-032 SHALL cover single-step: step_mode=1 with three step_req pulses -> exactly three cycles with pc_enable=1 and cycle_count +3.
REQ-033 SHALL cover reset during DRAIN: reset=0 at counter=2 -> next cycle state RUN, halted=0, cycle_count=0.
REQ-034 SHALL cover counter wrap: cycle_count forced near 0xFFFFFFFF -> wraps to 0 on the next enabled cycle.
